dma_engine: RTL
===============

Name: dma_engine

Overview:
Memory-to-memory word-copy engine. It is a second initiator on the CPU memory bus, alongside the CPU. The CPU programs it through a responder register window (intended decode 0xF2000000, 16 bytes), in the same way as the ports and timer. Once started, it requests the bus from the top-level arbiter and performs read/write word copies using the existing bus timing: writes commit on the edge, and read data returns one cycle after the address.

Parameters:
LEN_BITS, 16, width of the word-count register; maximum transfer is 2^LEN_BITS-1 words.
ADDR_BITS, 32, bus address width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
chipSelect  input  1  register window selected (decoded in top)
regWrite  input  1  write strobe for the register window
regSelect  input  2  register index, busAddress[3:2]
regDataIn  input  32  CPU write data
regDataOut  output  32  register read data, registered
busRequest  output  1  request ownership of the bus
busGrant  input  1  arbiter grant; the arbiter holds it while busRequest is high
masterAddress  output  ADDR_BITS  initiator address
masterWriteEnable  output  1  initiator write strobe
masterDataOut  output  32  initiator write data
masterDataIn  input  32  bus read data, valid one cycle after the address
irq  output  1  one-cycle pulse on completion

Behaviour:
- Reset (rst low at a posedge): SRC, DST and LEN are 0, CTRL is 0, state is IDLE.
  - busRequest, masterWriteEnable and irq are 0.
  - masterAddress, masterDataOut and regDataOut are 0.
  - Reset mid-transfer abandons the transfer immediately; no further bus cycles occur.
- Registers, selected by regSelect:
  - 0 SRC: word-aligned; bits [1:0] are forced to 0 on write.
  - 1 DST: word-aligned, same rule.
  - 2 LEN: word count, zero-extended on read.
  - 3 CTRL/STATUS.
    - bit0 START: write-1 starts a transfer; reads as 0.
    - bit1 BUSY: read-only.
    - bit2 DONE: sticky; write-1 clears it.
    - bit3 ERR: sticky; write-1 clears it.
- Register access rules:
  - Writes to SRC, DST and LEN while BUSY are ignored.
  - START while BUSY is ignored.
  - regDataOut is loaded every cycle with the register selected in the previous cycle; this matches the 1-cycle bus read latency.
  - The working copies of address and count are internal; SRC, DST and LEN read back their programmed values throughout a transfer.
- START with LEN=0: no bus request is made. The next cycle sets DONE and pulses irq.
- START with LEN>0 loads the working counters and enters REQ with busRequest=1.
- FSM (IDLE -> REQ -> RD -> RDW -> WR -> (RD | FIN) -> IDLE):
  - REQ: wait for busGrant=1, then go to RD.
  - RD: masterAddress=srcPtr, masterWriteEnable=0.
  - RDW: masterDataIn is captured at the end of this cycle into the data register.
  - WR: masterAddress=dstPtr, masterWriteEnable=1, masterDataOut=the captured word.
    - srcPtr and dstPtr each advance by 4; the count decrements by 1.
    - If the count reaches 0, go to FIN; otherwise go to RD.
  - FIN: drop busRequest, set DONE, pulse irq for one cycle, return to IDLE.
- Throughput: 3 cycles per word once granted. For an N-word transfer, START write to irq takes 1 (REQ) + grant wait + 3N + 1 cycles.
- masterWriteEnable is high only in WR.
- busRequest is high in REQ, RD, RDW and WR only.
- Grant-loss rule: if busGrant drops in RD, RDW or WR:
  - abort immediately to IDLE with busRequest=0;
  - set ERR, leave DONE clear, no irq;
  - a write in progress in that cycle is suppressed (masterWriteEnable forced 0).
- Address wrap: pointers wrap modulo 2^ADDR_BITS with no error.
- DONE/ERR: set and write-1-clear in the same cycle resolves as set.

Decomposition:
- Shared package dma_pkg holds:
  - register index constants (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3);
  - CTRL bit positions;
  - FSM state encoding;
  - the default base address constant 0xF2000000.
- One sub-module, dma_regs: register file, START/clear decode, registered read mux.
- The top level dma_engine holds the FSM and the datapath.

Test Plan:
1. Program SRC=0x00000100, DST=0x00010000, LEN=4, START with grant tied 1.
   -> Exactly 4 reads at 0x100, 0x104, 0x108, 0x10C, each followed by a write to 0x10000 and onward with the matching data.
   -> irq fires 14 cycles after the START write; CTRL reads 0x4.
2. LEN=0, START.
   -> No busRequest; DONE=1 and a single irq one cycle later.
   -> Writing CTRL=0x4 clears DONE.
3. Hold busGrant=0 for 10 cycles after START.
   -> busRequest stays 1 with no bus activity; the transfer completes normally after grant.
   -> Write SRC=0xDEAD during the wait: ignored, SRC still reads the original value.
4. Drop busGrant during the WR of word 2 of a LEN=5 transfer.
   -> masterWriteEnable is 0 that cycle; busRequest falls the next cycle.
   -> ERR=1, DONE=0, no irq; only 1 word was written.
5. Assert rst low mid-transfer (LEN=8, after word 3).
   -> All outputs are 0 next cycle; CTRL reads 0 after reset.
   -> A fresh START restarts cleanly.
6. Write SRC=0x00000103.
   -> Reads back 0x00000100.
   -> A START while BUSY does not restart the counter (total words equals the original LEN).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants for the DMA word-copy engine: register map, CTRL bits, FSM encoding.
package dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 1;
  localparam int unsigned CTRL_DONE  = 2;
  localparam int unsigned CTRL_ERR   = 3;

  localparam logic [31:0] DMA_BASE = 32'hF200_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StRdw,
    StWr,
    StFin
  } dmaState_e;

endpackage

// File: rtl/dma_regs.sv
// DMA register window: programmed SRC/DST/LEN, sticky DONE/ERR, START decode and
// a read mux registered so data lines up with the bus read latency.
module dma_regs
  import dma_pkg::*;
#(
  parameter int unsigned LEN_BITS  = 16,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipSelect,
  input  logic                 regWrite,
  input  logic [1:0]           regSelect,
  input  logic [31:0]          regDataIn,
  input  logic                 busy,
  input  logic                 doneSet,
  input  logic                 errSet,
  output logic                 start,
  output logic [ADDR_BITS-1:0] srcAddr,
  output logic [ADDR_BITS-1:0] dstAddr,
  output logic [LEN_BITS-1:0]  lenCount,
  output logic [31:0]          regDataOut
);

  logic        wrEn;
  logic        wrCtrl;
  logic        doneQ;
  logic        errQ;
  logic [31:0] readMux;

  assign wrEn   = chipSelect & regWrite;
  assign wrCtrl = wrEn & (regSelect == REG_CTRL);
  assign start  = wrCtrl & regDataIn[CTRL_START] & ~busy;

  always_comb begin
    readMux = '0;
    unique case (regSelect)
      REG_SRC: readMux[ADDR_BITS-1:0] = srcAddr;
      REG_DST: readMux[ADDR_BITS-1:0] = dstAddr;
      REG_LEN: readMux[LEN_BITS-1:0]  = lenCount;
      REG_CTRL: begin
        readMux[CTRL_BUSY] = busy;
        readMux[CTRL_DONE] = doneQ;
        readMux[CTRL_ERR]  = errQ;
      end
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      srcAddr    <= '0;
      dstAddr    <= '0;
      lenCount   <= '0;
      doneQ      <= 1'b0;
      errQ       <= 1'b0;
      regDataOut <= '0;
    end else begin
      if (wrEn && !busy) begin
        if (regSelect == REG_SRC) srcAddr <= {regDataIn[ADDR_BITS-1:2], 2'b00};
        if (regSelect == REG_DST) dstAddr <= {regDataIn[ADDR_BITS-1:2], 2'b00};
        if (regSelect == REG_LEN) lenCount <= regDataIn[LEN_BITS-1:0];
      end
      // A set from the engine wins over a simultaneous write-1-clear.
      if (doneSet) doneQ <= 1'b1;
      else if (wrCtrl && regDataIn[CTRL_DONE]) doneQ <= 1'b0;
      if (errSet) errQ <= 1'b1;
      else if (wrCtrl && regDataIn[CTRL_ERR]) errQ <= 1'b0;
      regDataOut <= readMux;
    end
  end

endmodule

// File: rtl/dma_engine.sv
// Memory-to-memory word-copy engine: bus-initiator FSM and copy datapath,
// programmed through the dma_regs responder window.
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned LEN_BITS  = 16,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipSelect,
  input  logic                 regWrite,
  input  logic [1:0]           regSelect,
  input  logic [31:0]          regDataIn,
  output logic [31:0]          regDataOut,
  output logic                 busRequest,
  input  logic                 busGrant,
  output logic [ADDR_BITS-1:0] masterAddress,
  output logic                 masterWriteEnable,
  output logic [31:0]          masterDataOut,
  input  logic [31:0]          masterDataIn,
  output logic                 irq
);

  dmaState_e            state, stateNext;
  logic [ADDR_BITS-1:0] srcPtr, dstPtr, srcAddr, dstAddr;
  logic [LEN_BITS-1:0]  count, lenCount;
  logic [31:0]          dataReg;
  logic                 start, busy, doneSet, errSet;

  assign busy = (state != StIdle);

  dma_regs #(
    .LEN_BITS (LEN_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) uRegs (
    .clk       (clk),
    .rst       (rst),
    .chipSelect(chipSelect),
    .regWrite  (regWrite),
    .regSelect (regSelect),
    .regDataIn (regDataIn),
    .busy      (busy),
    .doneSet   (doneSet),
    .errSet    (errSet),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .lenCount  (lenCount),
    .regDataOut(regDataOut)
  );

  always_comb begin
    stateNext         = state;
    busRequest        = 1'b0;
    masterAddress     = '0;
    masterWriteEnable = 1'b0;
    masterDataOut     = '0;
    irq               = 1'b0;
    doneSet           = 1'b0;
    errSet            = 1'b0;
    unique case (state)
      StIdle: begin
        if (start) stateNext = (lenCount == '0) ? StFin : StReq;
      end
      StReq: begin
        busRequest = 1'b1;
        if (busGrant) stateNext = StRd;
      end
      StRd: begin
        busRequest    = 1'b1;
        masterAddress = srcPtr;
        stateNext     = busGrant ? StRdw : StIdle;
        errSet        = ~busGrant;
      end
      StRdw: begin
        busRequest = 1'b1;
        stateNext  = busGrant ? StWr : StIdle;
        errSet     = ~busGrant;
      end
      StWr: begin
        busRequest    = 1'b1;
        masterAddress = dstPtr;
        masterDataOut = dataReg;
        // Losing the grant here must not commit the write.
        if (busGrant) begin
          masterWriteEnable = 1'b1;
          stateNext = (count == LEN_BITS'(1)) ? StFin : StRd;
        end else begin
          stateNext = StIdle;
          errSet    = 1'b1;
        end
      end
      StFin: begin
        irq       = 1'b1;
        doneSet   = 1'b1;
        stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= StIdle;
      srcPtr  <= '0;
      dstPtr  <= '0;
      count   <= '0;
      dataReg <= '0;
    end else begin
      state <= stateNext;
      if (state == StIdle && start) begin
        srcPtr <= srcAddr;
        dstPtr <= dstAddr;
        count  <= lenCount;
      end
      if (state == StRdw) dataReg <= masterDataIn;
      if (state == StWr && busGrant) begin
        srcPtr <= srcPtr + ADDR_BITS'(4);
        dstPtr <= dstPtr + ADDR_BITS'(4);
        count  <= count - LEN_BITS'(1);
      end
    end
  end

endmodule
